// File: rtl/rpxx_pkg.sv
// Shared definitions for the RPxx drive command sequencer: state codes,
// CS1 function codes, register field extractors and function-class predicates.
package rpxx_pkg;

  // Drive sequencer state codes, also consumed by the error register.
  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_CLEAR   = 5'd1,
    ST_INVADDR = 5'd2,
    ST_ILLFUN  = 5'd3,
    ST_WRLOCK  = 5'd4,
    ST_SEEKDLY = 5'd5,
    ST_DATA    = 5'd6,
    ST_NEXT    = 5'd7,
    ST_DONE    = 5'd8
  } state_t;

  // CS1 function codes (octal, as written in the drive documentation).
  localparam logic [4:0] FUN_NOP     = 5'o00;
  localparam logic [4:0] FUN_UNLOAD  = 5'o01;
  localparam logic [4:0] FUN_SEEK    = 5'o02;
  localparam logic [4:0] FUN_RECAL   = 5'o03;
  localparam logic [4:0] FUN_DRVCLR  = 5'o04;
  localparam logic [4:0] FUN_RELEASE = 5'o05;
  localparam logic [4:0] FUN_OFFSET  = 5'o06;
  localparam logic [4:0] FUN_CENTER  = 5'o07;
  localparam logic [4:0] FUN_PRESET  = 5'o10;
  localparam logic [4:0] FUN_PAKACK  = 5'o11;
  localparam logic [4:0] FUN_SEARCH  = 5'o14;
  localparam logic [4:0] FUN_WRCHK   = 5'o24;
  localparam logic [4:0] FUN_WRCHKH  = 5'o25;
  localparam logic [4:0] FUN_WRITE   = 5'o30;
  localparam logic [4:0] FUN_WRHDR   = 5'o31;
  localparam logic [4:0] FUN_READ    = 5'o34;
  localparam logic [4:0] FUN_RDHDR   = 5'o35;

  // Field extractors for CS1, DA and DC.
  function automatic logic [4:0] cs1_fun(input logic [5:0] cs1_lo);
    return cs1_lo[5:1];
  endfunction

  function automatic logic cs1_go(input logic [5:0] cs1_lo);
    return cs1_lo[0];
  endfunction

  function automatic logic [5:0] da_sa(input logic [15:0] da);
    return da[5:0];
  endfunction

  function automatic logic [5:0] da_ta(input logic [15:0] da);
    return da[13:8];
  endfunction

  function automatic logic [9:0] dc_dca(input logic [15:0] dc);
    return dc[9:0];
  endfunction

  // Functions that move sectors through the data path.
  function automatic logic isDATAFUN(input logic [4:0] fun);
    return (fun == FUN_WRCHK) || (fun == FUN_WRCHKH) || (fun == FUN_WRITE) ||
           (fun == FUN_WRHDR) || (fun == FUN_READ)   || (fun == FUN_RDHDR);
  endfunction

  // Functions that modify the media and therefore honour write lock.
  function automatic logic isWRITEFUN(input logic [4:0] fun);
    return (fun == FUN_WRITE) || (fun == FUN_WRHDR);
  endfunction

  function automatic logic isLEGALFUN(input logic [4:0] fun);
    return isDATAFUN(fun) || (fun <= FUN_PAKACK) || (fun == FUN_SEARCH);
  endfunction

  // Functions whose disk address must lie inside the pack geometry.
  function automatic logic isADDRFUN(input logic [4:0] fun);
    return isDATAFUN(fun) || (fun == FUN_SEEK) || (fun == FUN_SEARCH);
  endfunction

  // Functions that spend time positioning the heads.
  function automatic logic isSEEKFUN(input logic [4:0] fun);
    return isADDRFUN(fun) || (fun == FUN_RECAL);
  endfunction

endpackage

// File: rtl/rpxx_addrchk.sv
// Disk address comparators: in-range check for command decode and
// last-sector detection for the end-of-pack check between sectors.
module rpxx_addrchk (
  input  logic [5:0] sa,
  input  logic [5:0] ta,
  input  logic [9:0] dca,
  input  logic [5:0] last_sector,
  input  logic [5:0] last_track,
  input  logic [9:0] last_cyl,
  output logic       in_range,
  output logic       at_last
);

  // Pure comparators; both results are consumed in the same cycle.
  always_comb begin
    in_range = (sa <= last_sector) && (ta <= last_track) && (dca <= last_cyl);
    at_last  = (sa == last_sector) && (ta == last_track) && (dca == last_cyl);
  end

endmodule

// File: rtl/rpxx_ctrl.sv
// Per-drive RPxx command sequencer: accepts CS1 GO writes, validates the
// command, times the seek, handshakes sectors with the data path and
// produces the attention pulse at command completion.
module rpxx_ctrl
  import rpxx_pkg::*;
#(
  parameter int SEEK_DLY = 100,
  parameter int DLY_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [35:0] rpDATAI,
  input  logic        rpcs1WRITE,
  input  logic [15:0] rpDA,
  input  logic [15:0] rpDC,
  input  logic [5:0]  lastSECTOR,
  input  logic [5:0]  lastTRACK,
  input  logic [9:0]  lastCYL,
  input  logic        rpWRL,
  input  logic        xfrACK,
  input  logic        wcZERO,
  output logic [4:0]  state,
  output logic        incSECTOR,
  output logic        xfrREQ,
  output logic        xfrWRITE,
  output logic        rpDRY,
  output logic        rpATA
);

  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(SEEK_DLY - 1);

  state_t           state_q, state_d;
  logic [4:0]       fun_q, fun_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             incsec_q, xfrreq_q, xfrwrite_q, drdy_q, ata_q;

  logic [4:0] fun_in;
  logic       go_in;
  logic       in_range;
  logic       at_last;
  logic       unused_bits;

  assign fun_in      = cs1_fun(rpDATAI[5:0]);
  assign go_in       = cs1_go(rpDATAI[5:0]);
  assign unused_bits = ^{rpDATAI[35:6], rpDA[15:14], rpDA[7:6], rpDC[15:10]};

  rpxx_addrchk u_addrchk (
    .sa          (da_sa(rpDA)),
    .ta          (da_ta(rpDA)),
    .dca         (dc_dca(rpDC)),
    .last_sector (lastSECTOR),
    .last_track  (lastTRACK),
    .last_cyl    (lastCYL),
    .in_range    (in_range),
    .at_last     (at_last)
  );

  // Next-state decode: command acceptance, validation and sector sequencing.
  always_comb begin
    state_d = state_q;
    fun_d   = fun_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rpcs1WRITE && go_in) begin
            fun_d = fun_in;
            if (!isLEGALFUN(fun_in))                  state_d = ST_ILLFUN;
            else if (fun_in == FUN_DRVCLR)            state_d = ST_CLEAR;
            else if (isADDRFUN(fun_in) && !in_range)  state_d = ST_INVADDR;
            else if (isWRITEFUN(fun_in) && rpWRL)     state_d = ST_WRLOCK;
            else if (isSEEKFUN(fun_in)) begin
              state_d = ST_SEEKDLY;
              cnt_d   = DLY_LOAD;
            end else                                  state_d = ST_DONE;
          end
        end
        ST_CLEAR, ST_INVADDR, ST_ILLFUN, ST_WRLOCK: state_d = ST_DONE;
        ST_SEEKDLY: begin
          if (cnt_q == '0) state_d = isDATAFUN(fun_q) ? ST_DATA : ST_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_DATA: begin
          if (xfrACK) state_d = wcZERO ? ST_DONE : ST_NEXT;
        end
        // rpDA still holds the sector just transferred during NEXT.
        ST_NEXT: state_d = at_last ? ST_DONE : ST_DATA;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with outputs registered from the next state, so every
  // output lines up with the state it belongs to. Attention is suppressed
  // only for DONE reached straight from a completed DATA transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fun_q      <= FUN_NOP;
      cnt_q      <= '0;
      incsec_q   <= 1'b0;
      xfrreq_q   <= 1'b0;
      xfrwrite_q <= 1'b0;
      drdy_q     <= 1'b1;
      ata_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fun_q      <= fun_d;
      cnt_q      <= cnt_d;
      incsec_q   <= (state_d == ST_NEXT);
      xfrreq_q   <= (state_d == ST_DATA);
      xfrwrite_q <= (state_d == ST_DATA) && isWRITEFUN(fun_d);
      drdy_q     <= (state_d == ST_IDLE);
      ata_q      <= (state_d == ST_DONE) && (state_q != ST_DATA);
    end
  end

  assign state     = state_q;
  assign incSECTOR = incsec_q;
  assign xfrREQ    = xfrreq_q;
  assign xfrWRITE  = xfrwrite_q;
  assign rpDRY     = drdy_q;
  assign rpATA     = ata_q;

endmodule

// File: tb/tb_rpxx_ctrl.sv
// Directed bench for rpxx_ctrl with SEEK_DLY = 4 and an RP06-like geometry.
module tb_rpxx_ctrl;

  logic        clk, rst, clr;
  logic [35:0] rpDATAI;
  logic        rpcs1WRITE;
  logic [15:0] rpDA, rpDC;
  logic [5:0]  lastSECTOR, lastTRACK;
  logic [9:0]  lastCYL;
  logic        rpWRL, xfrACK, wcZERO;
  logic [4:0]  state;
  logic        incSECTOR, xfrREQ, xfrWRITE, rpDRY, rpATA;

  int n_checks = 0;
  int n_errors = 0;
  int ata_cnt = 0;
  int inc_cnt = 0;
  int req_cnt = 0;
  int a0, i0, r0;

  rpxx_ctrl #(.SEEK_DLY(4), .DLY_W(10)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rpDATAI(rpDATAI), .rpcs1WRITE(rpcs1WRITE),
    .rpDA(rpDA), .rpDC(rpDC), .lastSECTOR(lastSECTOR), .lastTRACK(lastTRACK),
    .lastCYL(lastCYL), .rpWRL(rpWRL), .xfrACK(xfrACK), .wcZERO(wcZERO),
    .state(state), .incSECTOR(incSECTOR), .xfrREQ(xfrREQ), .xfrWRITE(xfrWRITE),
    .rpDRY(rpDRY), .rpATA(rpATA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rpATA) ata_cnt++;
    if (incSECTOR) inc_cnt++;
    if (xfrREQ) req_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cs1_write(input logic [35:0] v);
    rpDATAI    = v;
    rpcs1WRITE = 1'b1;
    tick();
    rpcs1WRITE = 1'b0;
  endtask

  task automatic wait_state(input logic [4:0] s, input int maxc, input string tag);
    int n = 0;
    while (state !== s && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {27'd0, state}, {27'd0, s});
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; rpDATAI = '0; rpcs1WRITE = 1'b0;
    rpDA = '0; rpDC = '0; lastSECTOR = 6'd21; lastTRACK = 6'd18; lastCYL = 10'd814;
    rpWRL = 1'b0; xfrACK = 1'b0; wcZERO = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_dry", rpDRY, 1);
    chk("rst_req", xfrREQ, 0);
    chk("rst_inc", incSECTOR, 0);
    chk("rst_ata", rpATA, 0);
    chk("rst_wr", xfrWRITE, 0);

    // READ at DA 0 / DC 0, single sector; an early xfrACK in SEEKDLY is ignored.
    a0 = ata_cnt;
    wcZERO = 1'b1;
    cs1_write(36'o71);
    for (int i = 0; i < 4; i++) begin
      chk("rd_seek", state, 5);
      chk("rd_seek_dry", rpDRY, 0);
      xfrACK = (i == 1);
      tick();
    end
    xfrACK = 1'b0;
    chk("rd_data", state, 6);
    chk("rd_req", xfrREQ, 1);
    chk("rd_dir", xfrWRITE, 0);
    repeat (9) tick();
    chk("rd_hold", state, 6);
    xfrACK = 1'b1; tick(); xfrACK = 1'b0;
    chk("rd_done", state, 8);
    chk("rd_done_ata", rpATA, 0);
    chk("rd_done_dry", rpDRY, 0);
    tick();
    chk("rd_idle", state, 0);
    chk("rd_idle_dry", rpDRY, 1);
    chk("rd_no_ata", ata_cnt - a0, 0);

    // WRITE with write lock.
    rpWRL = 1'b1;
    r0 = req_cnt;
    cs1_write(36'o61);
    chk("wrl_state", state, 4);
    tick();
    chk("wrl_done", state, 8);
    chk("wrl_ata", rpATA, 1);
    tick();
    chk("wrl_idle", state, 0);
    chk("wrl_noreq", req_cnt - r0, 0);
    rpWRL = 1'b0;

    // WRITE without lock drives the write direction.
    cs1_write(36'o61);
    wait_state(5'd6, 10, "wr_data");
    chk("wr_dir", xfrWRITE, 1);
    xfrACK = 1'b1; wcZERO = 1'b1; tick(); xfrACK = 1'b0;
    chk("wr_done", state, 8);
    chk("wr_done_ata", rpATA, 0);
    tick();

    // SEEK just outside and just inside the last cylinder.
    rpDC = 16'd815;
    cs1_write(36'o05);
    chk("sk_inv", state, 2);
    tick();
    chk("sk_inv_done", state, 8);
    chk("sk_inv_ata", rpATA, 1);
    tick();
    chk("sk_inv_idle", state, 0);
    rpDC = 16'd814;
    cs1_write(36'o05);
    for (int i = 0; i < 4; i++) begin
      chk("sk_seek", state, 5);
      tick();
    end
    chk("sk_done", state, 8);
    chk("sk_ata", rpATA, 1);
    tick();
    chk("sk_idle", state, 0);

    // CS1 write with GO clear does nothing.
    cs1_write(36'o70);
    chk("nogo_state", state, 0);
    chk("nogo_dry", rpDRY, 1);

    // DRVCLR.
    cs1_write(36'o11);
    chk("clr_state", state, 1);
    tick();
    chk("clr_done", state, 8);
    chk("clr_ata", rpATA, 1);
    tick();

    // Illegal function; a GO write during the command is ignored,
    // and the first GO write back in IDLE is accepted.
    cs1_write(36'o45);
    chk("ill_state", state, 3);
    cs1_write(36'o71);
    chk("ill_done", state, 8);
    chk("ill_ata", rpATA, 1);
    tick();
    chk("ill_idle", state, 0);
    cs1_write(36'o01);
    chk("b2b_done", state, 8);
    chk("b2b_ata", rpATA, 1);
    tick();
    chk("b2b_idle", state, 0);

    // READ at the last sector of the pack: overflow after one sector.
    rpDA = 16'h1215; rpDC = 16'd814; wcZERO = 1'b0;
    cs1_write(36'o71);
    wait_state(5'd6, 10, "ovf_data");
    i0 = inc_cnt;
    xfrACK = 1'b1; tick(); xfrACK = 1'b0;
    chk("ovf_next", state, 7);
    chk("ovf_inc", incSECTOR, 1);
    tick();
    chk("ovf_done", state, 8);
    chk("ovf_ata", rpATA, 1);
    tick();
    chk("ovf_idle", state, 0);
    chk("ovf_inc_cnt", inc_cnt - i0, 1);

    // Multi-sector READ: three NEXT passes, then word count exhausted.
    rpDA = '0; rpDC = '0; wcZERO = 1'b0;
    cs1_write(36'o71);
    wait_state(5'd6, 10, "ms_data");
    i0 = inc_cnt; a0 = ata_cnt;
    for (int k = 0; k < 3; k++) begin
      xfrACK = 1'b1; tick(); xfrACK = 1'b0;
      chk("ms_next", state, 7);
      tick();
      rpDA = rpDA + 16'd1;
      chk("ms_back", state, 6);
      chk("ms_inc_low", incSECTOR, 0);
    end
    wcZERO = 1'b1;
    xfrACK = 1'b1; tick(); xfrACK = 1'b0;
    chk("ms_done", state, 8);
    chk("ms_ata", rpATA, 0);
    tick();
    chk("ms_idle", state, 0);
    chk("ms_inc_cnt", inc_cnt - i0, 3);
    chk("ms_no_ata", ata_cnt - a0, 0);

    // Controller clear in the middle of DATA.
    rpDA = '0; wcZERO = 1'b0;
    cs1_write(36'o71);
    wait_state(5'd6, 10, "cl_data");
    tick(); tick();
    a0 = ata_cnt;
    clr = 1'b1; tick(); clr = 1'b0;
    chk("cl_state", state, 0);
    chk("cl_req", xfrREQ, 0);
    chk("cl_dry", rpDRY, 1);
    tick(); tick();
    chk("cl_no_ata", ata_cnt - a0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpxx_ctrl.md
Name: rpxx_ctrl

Overview:
- Per-drive RPxx command sequencer.
- Decodes CS1 GO writes, validates the function and disk address, checks write lock, and times seeks.
- Handshakes each sector with the RH11 data path and pulses incSECTOR between sectors.
- Drives the state, incSECTOR and drive-ready signals consumed by the RPxx error, status and disk-address registers.

Parameters:
- SEEK_DLY, 100, clocks spent in SEEKDLY for SEEK/RECAL/SEARCH and before the first data sector.
- DLY_W, 10, width of the seek delay counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clr  in  1  controller clear; synchronous abort to IDLE
- rpDATAI  in  36  bus write data; CS1 FUN = bits 5:1, GO = bit 0
- rpcs1WRITE  in  1  CS1 write strobe
- rpDA  in  16  desired address; SA = bits 5:0, TA = bits 13:8
- rpDC  in  16  desired cylinder; DCA = bits 9:0
- lastSECTOR  in  6  geometry limit
- lastTRACK  in  6  geometry limit
- lastCYL  in  10  geometry limit
- rpWRL  in  1  write-protect switch
- xfrACK  in  1  data path finished current sector (1-cycle pulse)
- wcZERO  in  1  RH11 word count exhausted
- state  out  5  current state code
- incSECTOR  out  1  1-cycle pulse, advance DA
- xfrREQ  out  1  sector transfer request, held high in DATA
- xfrWRITE  out  1  direction of the current transfer (1 = WRITE/WRHDR)
- rpDRY  out  1  drive ready (state == IDLE)
- rpATA  out  1  1-cycle attention pulse

Behaviour:
- Reset or clr → state IDLE (0). Outputs are then:
  - incSECTOR = 0, xfrREQ = 0, xfrWRITE = 0, rpATA = 0
  - rpDRY = 1
  - delay counter = 0
  - clr has priority over every other event.
- State codes, 5-bit:
  - IDLE = 0, CLEAR = 1, INVADDR = 2, ILLFUN = 3, WRLOCK = 4
  - SEEKDLY = 5, DATA = 6, NEXT = 7, DONE = 8
- Command accept:
  - Condition: rpcs1WRITE & GO & state == IDLE.
  - The FUN field is latched into funREG.
  - Next state is valid on the following cycle.
  - A CS1 write while not IDLE is ignored here; the error register flags RMR.
  - A CS1 write with GO = 0 does nothing.
- Function codes (FUN, octal):
  - NOP 00, UNLOAD 01, SEEK 02, RECAL 03, DRVCLR 04, RELEASE 05, OFFSET 06, CENTER 07
  - PRESET 10, PAKACK 11, SEARCH 14
  - WRCHK 24, WRCHKH 25, WRITE 30, WRHDR 31, READ 34, RDHDR 35
  - Any other code → ILLFUN.
- Decode priority from IDLE:
  1. Illegal code → ILLFUN.
  2. DRVCLR → CLEAR.
  3. SEEK/SEARCH/data functions with SA > lastSECTOR, TA > lastTRACK, or DCA > lastCYL → INVADDR.
  4. WRITE/WRHDR with rpWRL = 1 → WRLOCK.
  5. SEEK/RECAL/SEARCH/data functions → SEEKDLY, counter loaded with SEEK_DLY-1.
  6. All remaining functions → DONE.
- CLEAR, INVADDR, ILLFUN, WRLOCK each last exactly 1 cycle, then DONE.
- SEEKDLY:
  - Counter decrements each cycle.
  - At 0: data functions go to DATA; others go to DONE.
  - SEEK_DLY = 1 gives one cycle in SEEKDLY.
- DATA:
  - xfrREQ = 1; xfrWRITE = 1 for WRITE/WRHDR.
  - Waits on xfrACK indefinitely.
  - On xfrACK: wcZERO = 1 → DONE; otherwise → NEXT.
  - xfrACK outside DATA is ignored.
- NEXT:
  - incSECTOR = 1 for exactly this cycle.
  - If SA == lastSECTOR & TA == lastTRACK & DCA == lastCYL (address overflow; error register sets AOE from the same pulse) → DONE.
  - Otherwise → DATA.
  - rpDA seen in the cycle after NEXT is already incremented.
- DONE:
  - Lasts 1 cycle, then IDLE.
  - rpATA = 1 in DONE when funREG is not a data function, or when DONE was entered from an error state, NEXT-overflow, or CLEAR.
  - rpATA = 0 for normal data completion.
- rpDRY is low in every state except IDLE.
- Back-to-back commands: a GO write in the IDLE cycle immediately after DONE is accepted.

Decomposition:
- Package rpxx_pkg holds:
  - state codes and function codes
  - field-extract functions for CS1 FUN/GO, DA SA/TA, DC DCA
  - predicates isDATAFUN, isWRITEFUN, isLEGALFUN
- The same package constants feed the error register's state-code inputs.
- One sub-module, rpxx_addrchk: combinational in-range and last-sector comparators shared by the decode and NEXT logic.

Test Plan:
- Geometry sector 0..21, track 0..18, cyl 0..814; SEEK_DLY = 4; DA = 0, DC = 0; write CS1 = 071 (READ+GO); xfrACK after 10 cycles with wcZERO = 1 → state 5 for 4 cycles, DATA with xfrREQ = 1, xfrWRITE = 0, DONE 1 cycle, IDLE; rpATA never 1; rpDRY low throughout.
- CS1 = 061 (WRITE) with rpWRL = 1 → WRLOCK (4) 1 cycle, DONE with rpATA = 1, xfrREQ never asserted.
- CS1 = 005 (SEEK) with DC = 815 → INVADDR 1 cycle, DONE, rpATA = 1. Same with DC = 814 → SEEKDLY 4 cycles, DONE, rpATA = 1.
- CS1 = 045 (FUN 22, illegal) → ILLFUN 1 cycle, DONE. A CS1 GO write during that command is ignored; the next write after IDLE is accepted.
- READ at DA SA = 21, TA = 18, DC = 814 with wcZERO = 0 → one xfrACK, NEXT with incSECTOR pulse, DONE with rpATA = 1, no second DATA entry.
- READ with wcZERO = 0, xfrACK ×3 then wcZERO = 1 → three incSECTOR pulses; clr asserted mid-DATA → IDLE next cycle, xfrREQ = 0, no rpATA.
